cal_set_ctrl: RTL and testbench
===============================

// Module: cal_set_ctrl
// PURPOSE
//  Key-driven edit-mode controller for the calendar datapath (cal).
//  Debounces both keys, walks a field cursor over year/month/day/hour/min/sec,
//  and issues single-cycle increment strobes with hold-to-repeat.
//  Also freezes timekeeping and drives the digit-blink mask for display_drive.
//  Sits between the board keys and cal/display_drive; clocked by clk_in (100 MHz).
// PARAMETERS
//  DEB_MS     20     consecutive stable 1 kHz samples before a key level is accepted
//  HOLD_MS    1000   key[1] hold time before auto-repeat starts
//  REPEAT_MS  250    auto-repeat interval once repeating
//  TIMEOUT_MS 10000  idle time in EDIT before automatic return to RUN
// PORTS
//  clk_in      in   1  system clock, 100 MHz
//  rst         in   1  synchronous, active-high reset
//  tick_1khz   in   1  one-clk_in-cycle strobe at 1 kHz
//  tick_2hz    in   1  one-clk_in-cycle strobe at 2 Hz (blink phase)
//  key         in   2  raw keys, 1 = pressed; [0] field/mode, [1] increment
//  edit_active out  1  1 while in EDIT; cal holds its seconds counter
//  field_sel   out  3  0 yr,1 mon,2 day,3 hr,4 min,5 sec; 7 when RUN
//  inc_stb     out  1  one-cycle increment request for field_sel
//  page        out  1  0 = date page (YYYYMMDD), 1 = time page (--HHMMSS)
//  blink_mask  out  8  1 = blank that digit this cycle (bit7 = leftmost)
// BEHAVIOUR
//  Reset: edit_active=0, field_sel=7, inc_stb=0, page=0, blink_mask=0; all counters 0.
//  Debounce: per key, sample only on tick_1khz; accepted level changes after
//   DEB_MS equal consecutive samples differing from current level. Press event
//   = accepted 0->1, registered, one cycle wide.
//  FSM states RUN, EDIT:
//   RUN : key[0] press -> EDIT, field_sel=0. key[1] ignored. page follows nothing
//         (held at last value).
//   EDIT: key[0] press -> field_sel+1; press on field 5 -> RUN, field_sel=7.
//         key[1] press -> inc_stb next cycle (latency 1 from press event).
//         key[1] held: after HOLD_MS ticks, inc_stb each REPEAT_MS ticks until release.
//         Idle counter (tick_1khz) clears on any press event; reaching TIMEOUT_MS -> RUN.
//  Simultaneous press events same cycle: key[0] wins, key[1] event dropped;
//   no inc_stb on a cycle that changes field_sel or state.
//  Hold counter clears on key[1] release and on any field change.
//  page = 0 for fields 0-2, 1 for fields 3-5 (updated with field_sel).
//  blink phase toggles on tick_2hz, cleared on entry to EDIT (visible first).
//  blink_mask when phase=1: yr 8'hF0, mon 8'h0C, day 8'h03, hr 8'h30,
//   min 8'h0C, sec 8'h03; phase=0 or RUN -> 8'h00.
//  Wrap of field values is owned by cal, not this block.
//  Counters saturate; no wrap of hold/idle counters (widths sized from params).
//  rst mid-edit: immediate RUN defaults next cycle, pending strobe discarded.
// STRUCTURE
//  cal_defs.vh: field codes (FLD_YR..FLD_SEC, FLD_NONE=7), state codes, mask constants.
//  Sub-module key_debounce (DEB_MS param; clk_in, rst, tick, raw -> level, press),
//   instantiated twice. FSM, hold/repeat, idle timeout and mask decode in top body.
// TESTING (bench drives tick_1khz every 8 clocks to shorten ms)
//  Bounce key[0] 5 times <20 ticks then hold 25 ticks -> one press, edit_active=1, field_sel=0, page=0.
//  In EDIT field 3, key[1] 40-tick press -> exactly one inc_stb, field_sel stays 3.
//  Hold key[1] 1600 ticks -> 1 + 3 strobes (at ~1020, 1270, 1520 ticks); release stops them.
//  key[0] and key[1] accepted same cycle on field 1 -> field_sel=2, no inc_stb.
//  EDIT idle 10000 ticks -> edit_active=0, field_sel=7, blink_mask=0.
//  rst asserted mid key[1] repeat -> next cycle all outputs at reset values, no strobe.

Source files
------------

// File: rtl/cal_set_ctrl_pkg.sv
// Shared field codes, FSM states and blink-mask constants for cal_set_ctrl.
package cal_set_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  typedef logic [2:0] field_t;

  localparam field_t FLD_YR   = 3'd0;
  localparam field_t FLD_MON  = 3'd1;
  localparam field_t FLD_DAY  = 3'd2;
  localparam field_t FLD_HR   = 3'd3;
  localparam field_t FLD_MIN  = 3'd4;
  localparam field_t FLD_SEC  = 3'd5;
  localparam field_t FLD_NONE = 3'd7;

  // Digit positions, bit7 = leftmost: date page YYYYMMDD, time page --HHMMSS.
  localparam logic [7:0] MASK_YR  = 8'hF0;
  localparam logic [7:0] MASK_MON = 8'h0C;
  localparam logic [7:0] MASK_DAY = 8'h03;
  localparam logic [7:0] MASK_HR  = 8'h30;
  localparam logic [7:0] MASK_MIN = 8'h0C;
  localparam logic [7:0] MASK_SEC = 8'h03;

  function automatic logic [7:0] field_mask(input field_t f);
    logic [7:0] m;
    m = '0;
    case (f)
      FLD_YR:  m = MASK_YR;
      FLD_MON: m = MASK_MON;
      FLD_DAY: m = MASK_DAY;
      FLD_HR:  m = MASK_HR;
      FLD_MIN: m = MASK_MIN;
      FLD_SEC: m = MASK_SEC;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Time page holds hour/min/sec; date page holds year/month/day.
  function automatic logic field_page(input field_t f);
    return (f == FLD_HR) || (f == FLD_MIN) || (f == FLD_SEC);
  endfunction

endpackage

// File: rtl/cal_set_ctrl_key_debounce.sv
// Single-key debouncer: a new level is accepted after DEB_MS consecutive
// tick samples that differ from the current level. raw is expected to be
// already synchronous to clk_in.
module key_debounce #(
  parameter int unsigned DEB_MS = 20
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEB_MS < 2) ? 1 : $clog2(DEB_MS + 1);

  logic [CW-1:0] cnt_q;

  // Count differing samples; any sample equal to the level restarts the run.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      level <= 1'b0;
      press <= 1'b0;
      cnt_q <= '0;
    end else begin
      press <= 1'b0;
      if (tick) begin
        if (raw != level) begin
          if (cnt_q == CW'(DEB_MS - 1)) begin
            level <= raw;
            press <= raw;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/cal_set_ctrl.sv
// Key-driven edit-mode controller for the calendar datapath: field cursor,
// increment strobes with hold-to-repeat, idle timeout and blink mask.
module cal_set_ctrl
  import cal_set_ctrl_pkg::*;
#(
  parameter int unsigned DEB_MS     = 20,
  parameter int unsigned HOLD_MS    = 1000,
  parameter int unsigned REPEAT_MS  = 250,
  parameter int unsigned TIMEOUT_MS = 10000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1khz,
  input  logic       tick_2hz,
  input  logic [1:0] key,
  output logic       edit_active,
  output logic [2:0] field_sel,
  output logic       inc_stb,
  output logic       page,
  output logic [7:0] blink_mask
);

  localparam int unsigned HW = $clog2(HOLD_MS + 1);
  localparam int unsigned RW = (REPEAT_MS < 2) ? 1 : $clog2(REPEAT_MS + 1);
  localparam int unsigned IW = $clog2(TIMEOUT_MS + 1);

  logic [1:0] level, press;

  key_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (tick_1khz),
    .raw    (key[0]),
    .level  (level[0]),
    .press  (press[0])
  );

  key_debounce #(.DEB_MS(DEB_MS)) u_deb_inc (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (tick_1khz),
    .raw    (key[1]),
    .level  (level[1]),
    .press  (press[1])
  );

  state_t        state_q, state_d;
  field_t        field_q, field_d;
  logic          page_q, page_d;
  logic          phase_q, phase_d;
  logic          inc_q, inc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rep_q;
  logic          holding, hold_sat, rep_fire, field_chg, timeout;

  assign holding   = (state_q == ST_EDIT) && level[1];
  assign hold_sat  = (hold_q == HW'(HOLD_MS));
  assign field_chg = (field_d != field_q);
  assign timeout   = (idle_q == IW'(TIMEOUT_MS));

  // Repeat fires on the HOLD_MS-th held tick, then every REPEAT_MS ticks.
  always_comb begin
    rep_fire = 1'b0;
    if (holding && tick_1khz) begin
      if (!hold_sat)
        rep_fire = (hold_q == HW'(HOLD_MS - 1));
      else
        rep_fire = (rep_q == RW'(REPEAT_MS - 1));
    end
  end

  // Hold/repeat counters: cleared on release, leaving EDIT or any field change.
  always_ff @(posedge clk_in) begin
    if (rst || !holding || field_chg) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else if (tick_1khz) begin
      if (!hold_sat)
        hold_q <= hold_q + HW'(1);
      else if (rep_q == RW'(REPEAT_MS - 1))
        rep_q <= '0;
      else
        rep_q <= rep_q + RW'(1);
    end
  end

  // FSM state and cursor registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_RUN;
      field_q <= FLD_NONE;
      page_q  <= 1'b0;
      phase_q <= 1'b0;
      inc_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      page_q  <= page_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      idle_q  <= idle_d;
    end
  end

  // Next state: a key[0] press or timeout takes priority and suppresses inc_stb.
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    page_d  = page_q;
    phase_d = phase_q;
    idle_d  = idle_q;
    inc_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        idle_d = '0;
        if (press[0]) begin
          state_d = ST_EDIT;
          field_d = FLD_YR;
          page_d  = 1'b0;
          phase_d = 1'b0;
        end
      end
      ST_EDIT: begin
        if (tick_2hz)
          phase_d = ~phase_q;
        if (press[0] || press[1])
          idle_d = '0;
        else if (tick_1khz && !timeout)
          idle_d = idle_q + IW'(1);

        if (press[0]) begin
          if (field_q == FLD_SEC) begin
            state_d = ST_RUN;
            field_d = FLD_NONE;
            phase_d = 1'b0;
          end else begin
            field_d = field_q + 3'd1;
            page_d  = field_page(field_q + 3'd1);
          end
        end else if (timeout) begin
          state_d = ST_RUN;
          field_d = FLD_NONE;
          phase_d = 1'b0;
        end else if (press[1] || rep_fire) begin
          inc_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        field_d = FLD_NONE;
      end
    endcase
  end

  // Output decode; the mask blanks the selected field during the odd blink phase.
  always_comb begin
    blink_mask = '0;
    if (state_q == ST_EDIT && phase_q)
      blink_mask = field_mask(field_q);
  end

  assign edit_active = (state_q == ST_EDIT);
  assign field_sel   = field_q;
  assign inc_stb     = inc_q;
  assign page        = page_q;

endmodule

// File: tb/tb_cal_set_ctrl.sv
module tb_cal_set_ctrl;

  localparam int DEB = 20;
  localparam int HOLD = 1000;
  localparam int REP = 250;
  localparam int TMO = 10000;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1khz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic [1:0] key = 2'b00;
  logic       edit_active;
  logic [2:0] field_sel;
  logic       inc_stb;
  logic       page;
  logic [7:0] blink_mask;

  cal_set_ctrl #(
    .DEB_MS(DEB), .HOLD_MS(HOLD), .REPEAT_MS(REP), .TIMEOUT_MS(TMO)
  ) dut (
    .clk_in(clk_in), .rst(rst), .tick_1khz(tick_1khz), .tick_2hz(tick_2hz),
    .key(key), .edit_active(edit_active), .field_sel(field_sel),
    .inc_stb(inc_stb), .page(page), .blink_mask(blink_mask)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int tper = 8;
  int tphase = 0;
  int tick_cnt = 0;
  int inc_cnt = 0;
  bit t2_req = 0;
  bit rnd_t2 = 0;

  // Behavioural reference: RUN is field 7; hold time kept as unbounded ms count.
  int m_lvl[2], m_run[2], m_pe[2];
  int m_field, m_page, m_phase, m_idle, m_held, m_inc;
  int mtab[6] = '{'hF0, 'h0C, 'h03, 'h30, 'h0C, 'h03};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = 0; m_run[k] = 0; m_pe[k] = 0;
    end
    m_field = 7; m_page = 0; m_phase = 0; m_idle = 0; m_held = 0; m_inc = 0;
  endfunction

  function automatic void model_update();
    int f, pe0, pe1, lvl1, k, to;
    bit fire;
    if (rst) begin
      model_reset();
      return;
    end
    f = m_field; pe0 = m_pe[0]; pe1 = m_pe[1]; lvl1 = m_lvl[1];
    k = m_held + 1;
    fire = (f != 7) && (lvl1 != 0) && tick_1khz &&
           (k == HOLD || (k > HOLD && (k - HOLD) % REP == 0));
    to = (m_idle == TMO);
    for (int i = 0; i < 2; i++) begin
      m_pe[i] = 0;
      if (tick_1khz) begin
        if (int'(key[i]) != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = int'(key[i]); m_pe[i] = m_lvl[i]; m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
    end
    m_inc = 0;
    if (f == 7) begin
      if (pe0 != 0) begin
        m_field = 0; m_page = 0; m_phase = 0; m_idle = 0;
      end
    end else begin
      if (tick_2hz) m_phase ^= 1;
      if (pe0 != 0 || pe1 != 0) m_idle = 0;
      else if (tick_1khz && m_idle < TMO) m_idle++;
      if (pe0 != 0) begin
        if (f == 5) begin m_field = 7; m_phase = 0; end
        else begin m_field = f + 1; m_page = (f + 1 >= 3); end
      end else if (to != 0) begin
        m_field = 7; m_phase = 0;
      end else if (pe1 != 0 || fire) m_inc = 1;
    end
    if (f == 7 || lvl1 == 0 || m_field != f) m_held = 0;
    else if (tick_1khz) m_held++;
  endfunction

  function automatic logic [31:0] model_vec();
    int mask;
    mask = (m_field == 7 || m_phase == 0) ? 0 : mtab[m_field];
    return ((m_field != 7) << 13) | (m_field << 10) | (m_inc << 9) | (m_page << 8) | mask;
  endfunction

  // One clock: drive inputs, advance model at the edge, compare 1 ns later.
  task automatic cyc();
    tick_1khz = (tphase == tper - 1);
    tphase = (tphase + 1 >= tper) ? 0 : tphase + 1;
    tick_2hz = t2_req || (rnd_t2 && $urandom_range(0, 63) == 0);
    t2_req = 0;
    @(posedge clk_in);
    model_update();
    #1;
    if (tick_1khz) tick_cnt++;
    if (inc_stb === 1'b1) inc_cnt++;
    chk("cycle", 32'({edit_active, field_sel, inc_stb, page, blink_mask}), model_vec());
  endtask

  task automatic ticks(input int n);
    int start;
    start = tick_cnt;
    while (tick_cnt - start < n) cyc();
  endtask

  task automatic do_reset();
    key = 2'b00;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic press0(input int n);
    for (int i = 0; i < n; i++) begin
      key[0] = 1'b1; ticks(22);
      key[0] = 1'b0; ticks(22);
    end
  endtask

  typedef struct {
    int n_key0;
    int n_t2;
    int exp_edit;
    int exp_field;
    int exp_page;
    int exp_mask;
  } vec_t;

  vec_t vt[11];

  initial begin
    model_reset();
    vt[0]  = '{0, 1, 0, 7, 0, 'h00};
    vt[1]  = '{1, 0, 1, 0, 0, 'h00};
    vt[2]  = '{1, 1, 1, 0, 0, 'hF0};
    vt[3]  = '{2, 1, 1, 1, 0, 'h0C};
    vt[4]  = '{3, 1, 1, 2, 0, 'h03};
    vt[5]  = '{4, 1, 1, 3, 1, 'h30};
    vt[6]  = '{5, 1, 1, 4, 1, 'h0C};
    vt[7]  = '{6, 1, 1, 5, 1, 'h03};
    vt[8]  = '{6, 2, 1, 5, 1, 'h00};
    vt[9]  = '{7, 1, 0, 7, 1, 'h00};
    vt[10] = '{3, 3, 1, 2, 0, 'h03};

    do_reset();
    chk("rst_edit", 32'(edit_active), 0);
    chk("rst_field", 32'(field_sel), 7);
    chk("rst_inc", 32'(inc_stb), 0);
    chk("rst_page", 32'(page), 0);
    chk("rst_mask", 32'(blink_mask), 0);

    // Field walk / page / blink table.
    tper = 4; tphase = 0;
    for (int r = 0; r < 11; r++) begin
      do_reset();
      press0(vt[r].n_key0);
      for (int p = 0; p < vt[r].n_t2; p++) begin
        t2_req = 1; cyc(); ticks(2);
      end
      chk($sformatf("tbl%0d_edit", r), 32'(edit_active), vt[r].exp_edit);
      chk($sformatf("tbl%0d_field", r), 32'(field_sel), vt[r].exp_field);
      chk($sformatf("tbl%0d_page", r), 32'(page), vt[r].exp_page);
      chk($sformatf("tbl%0d_mask", r), 32'(blink_mask), vt[r].exp_mask);
    end

    // Bouncing key[0] then a steady hold gives one press.
    tper = 8; tphase = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      key[0] = 1'b1; ticks(3);
      key[0] = 1'b0; ticks(2);
    end
    key[0] = 1'b1; ticks(25);
    chk("bounce_edit", 32'(edit_active), 1);
    chk("bounce_field", 32'(field_sel), 0);
    chk("bounce_page", 32'(page), 0);
    key[0] = 1'b0; ticks(25);

    // Short key[1] press on field 3.
    press0(3);
    chk("fld3", 32'(field_sel), 3);
    inc_cnt = 0;
    key[1] = 1'b1; ticks(40);
    key[1] = 1'b0; ticks(30);
    chk("short_inc", 32'(inc_cnt), 1);
    chk("short_field", 32'(field_sel), 3);

    // Long hold: initial strobe plus three repeats, none after release.
    inc_cnt = 0;
    key[1] = 1'b1; ticks(1600);
    key[1] = 1'b0; ticks(300);
    chk("hold_inc", 32'(inc_cnt), 4);

    // Simultaneous acceptance on field 1: key[0] wins.
    do_reset();
    press0(2);
    chk("sim_pre", 32'(field_sel), 1);
    inc_cnt = 0;
    key = 2'b11; ticks(25);
    chk("sim_field", 32'(field_sel), 2);
    chk("sim_inc", 32'(inc_cnt), 0);
    key = 2'b00; ticks(30);

    // Idle timeout.
    tper = 2; tphase = 0;
    ticks(9000);
    chk("idle_before", 32'(edit_active), 1);
    ticks(1100);
    chk("idle_edit", 32'(edit_active), 0);
    chk("idle_field", 32'(field_sel), 7);
    chk("idle_mask", 32'(blink_mask), 0);

    // Reset during auto-repeat.
    tper = 8; tphase = 0;
    do_reset();
    press0(1);
    inc_cnt = 0;
    key[1] = 1'b1; ticks(1100);
    chk("rpt_inc", 32'(inc_cnt), 2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_edit", 32'(edit_active), 0);
    chk("mid_field", 32'(field_sel), 7);
    chk("mid_inc", 32'(inc_stb), 0);
    chk("mid_page", 32'(page), 0);
    chk("mid_mask", 32'(blink_mask), 0);
    inc_cnt = 0;
    ticks(100);
    chk("post_rst_inc", 32'(inc_cnt), 0);
    chk("post_rst_edit", 32'(edit_active), 0);
    key = 2'b00;

    // Randomized key activity against the model.
    tper = 4; tphase = 0;
    rnd_t2 = 1;
    do_reset();
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      key = 2'($urandom_range(0, 3));
      ticks($urandom_range(1, 35));
    end
    rnd_t2 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
